// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use bubbles, branch/jump flushes,
// freeze across multi-cycle data-memory accesses with timeout abort, saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic             pc_src_branch,
    output logic             pc_src_jump,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TIMEOUT_IDX = WW'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WW-1:0]    wait_cnt_reg, wait_cnt_next;
    logic [WW-1:0]    frozen_idx;
    logic             frozen;
    logic             timeout;
    logic             load_use;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    // The entry cycle (RUN with an unfinished access) is frozen cycle 1; in MEM_WAIT the
    // register holds how many frozen cycles have already elapsed.
    always_comb begin
        frozen     = (state_reg == MEM_WAIT) ? !mem_ready : (mem_req & !mem_ready);
        frozen_idx = (state_reg == MEM_WAIT) ? (wait_cnt_reg + 1'b1) : WW'(1);
        timeout    = frozen & (frozen_idx == TIMEOUT_IDX);
        load_use   = ex_memread & (ex_rt != 5'd0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    end

    always_comb begin
        state_next    = RUN;
        wait_cnt_next = '0;
        if (frozen && !timeout) begin
            state_next    = MEM_WAIT;
            wait_cnt_next = frozen_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // While frozen, ID/EX contents are held, so branch/jump/load-use re-evaluate on release.
    always_comb begin
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        ifid_flush    = 1'b0;
        idex_en       = 1'b1;
        idex_flush    = 1'b0;
        exmem_en      = 1'b1;
        memwb_flush   = 1'b0;
        pc_src_branch = 1'b0;
        pc_src_jump   = 1'b0;
        mem_err       = 1'b0;
        if (frozen) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            mem_err     = timeout;
        end else if (ex_branch_taken) begin
            pc_src_branch = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_jump) begin
            pc_src_jump = 1'b1;
            ifid_flush  = 1'b1;
        end
        if (!rst_n) begin
            pc_en         = 1'b0;
            ifid_en       = 1'b0;
            ifid_flush    = 1'b0;
            idex_en       = 1'b0;
            idex_flush    = 1'b0;
            exmem_en      = 1'b0;
            memwb_flush   = 1'b0;
            pc_src_branch = 1'b0;
            pc_src_jump   = 1'b0;
            mem_err       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (!pc_en && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (ifid_flush && (flush_cnt_reg != {CNT_W{1'b1}}))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule
